// File: rtl/map_pkg.sv
// Shared map definitions: grid defaults, field widths, sprite codes and the
// scanner state encoding used by map walkers.
package map_pkg;

    localparam int MAP_W_DEFAULT = 21;
    localparam int MAP_H_DEFAULT = 25;
    localparam int COORD_W       = 5;
    localparam int SPRITE_W      = 3;
    localparam int COUNT_W       = 10;

    localparam logic [SPRITE_W-1:0] SPRITE_EMPTY  = 3'd0;
    localparam logic [SPRITE_W-1:0] SPRITE_PELLET = 3'd1;
    localparam logic [SPRITE_W-1:0] SPRITE_WALL   = 3'd2;
    localparam logic [SPRITE_W-1:0] SPRITE_POWER  = 3'd3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        EMIT,
        DONE
    } scan_state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/map_cell_counter.sv
// Raster-order x/y cell counter (x fastest) with wrap and a last-cell flag.
// Stays on the last cell once reached until cleared.
module map_cell_counter import map_pkg::*; #(
    parameter int MAP_W = MAP_W_DEFAULT,
    parameter int MAP_H = MAP_H_DEFAULT
) (
    input  logic               clock_50,
    input  logic               reset,
    input  logic               clear,
    input  logic               advance,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(MAP_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(MAP_H - 1);

    assign last = (x == X_LAST) && (y == Y_LAST);

    always_ff @(posedge clock_50) begin
        if (reset || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance && !last) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/map_scanner.sv
// Map read-port initiator: sweeps every cell, emits (x, y, sprite) records and
// counts pellets. Define MAP_SCANNER_SKIP_EMPTY_EN to suppress empty-cell records.
module map_scanner import map_pkg::*; #(
    parameter int                  MAP_W       = MAP_W_DEFAULT,
    parameter int                  MAP_H       = MAP_H_DEFAULT,
    parameter int                  RD_LAT      = 1,
    parameter logic [SPRITE_W-1:0] PELLET_CODE = SPRITE_PELLET
) (
    input  logic                clock_50,
    input  logic                reset,
    input  logic                start,
    output logic [COORD_W-1:0]  map_x,
    output logic [COORD_W-1:0]  map_y,
    output logic                readwrite,
    input  logic [SPRITE_W-1:0] map_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [COORD_W-1:0]  out_x,
    output logic [COORD_W-1:0]  out_y,
    output logic [SPRITE_W-1:0] out_sprite,
    output logic [COUNT_W-1:0]  pellet_count,
    output logic                busy,
    output logic                done
);

    localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

    scan_state_t        state;
    scan_state_t        next_state;
    logic [1:0]         wait_cnt;
    logic [COORD_W-1:0] cell_x;
    logic [COORD_W-1:0] cell_y;
    logic               last_cell;
    logic               clear_cells;
    logic               advance;
    logic               capture;

    map_cell_counter #(
        .MAP_W (MAP_W),
        .MAP_H (MAP_H)
    ) u_cells (
        .clock_50 (clock_50),
        .reset    (reset),
        .clear    (clear_cells),
        .advance  (advance),
        .x        (cell_x),
        .y        (cell_y),
        .last     (last_cell)
    );

    // The address comes straight from the cell counter, which only moves after
    // a record is finished, so it is stable for the whole read.
    assign map_x     = cell_x;
    assign map_y     = cell_y;
    assign readwrite = 1'b0;
    assign out_valid = (state == EMIT);
    assign busy      = (state == ISSUE) || (state == WAIT) || (state == EMIT);
    assign done      = (state == DONE);

    always_comb begin
        next_state  = state;
        clear_cells = 1'b0;
        advance     = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear_cells = 1'b1;
                    next_state  = ISSUE;
                end
            end
            ISSUE: next_state = WAIT;
            WAIT: begin
                if (wait_cnt == 2'd0) begin
                    capture = 1'b1;
`ifdef MAP_SCANNER_SKIP_EMPTY_EN
                    if (map_data == SPRITE_EMPTY) begin
                        if (last_cell) begin
                            next_state = DONE;
                        end else begin
                            advance    = 1'b1;
                            next_state = ISSUE;
                        end
                    end else begin
                        next_state = EMIT;
                    end
`else
                    next_state = EMIT;
`endif
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (last_cell) begin
                        next_state = DONE;
                    end else begin
                        advance    = 1'b1;
                        next_state = ISSUE;
                    end
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= 2'd0;
            out_x        <= '0;
            out_y        <= '0;
            out_sprite   <= '0;
            pellet_count <= '0;
        end else begin
            state <= next_state;
            if (state == ISSUE) begin
                wait_cnt <= WAIT_LOAD;
            end else if ((state == WAIT) && (wait_cnt != 2'd0)) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
            if (clear_cells) begin
                pellet_count <= '0;
            end
            if (capture) begin
                out_x      <= cell_x;
                out_y      <= cell_y;
                out_sprite <= map_data;
                if (map_data == PELLET_CODE) begin
                    pellet_count <= sat_inc(pellet_count);
                end
            end
        end
    end

endmodule

// File: tb/tb_map_scanner.sv
// Randomised self-checking bench for map_scanner across several grid shapes and
// read latencies, with a latency-accurate map model and a record scoreboard.
module tb_map_scanner;

    localparam int NI         = 4;
    localparam int SWEEP_LIM  = 20000;
`ifdef MAP_SCANNER_SKIP_EMPTY_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    function automatic int cfg_w(input int i);
        case (i)
            2:       return 1;
            3:       return 6;
            default: return 21;
        endcase
    endfunction

    function automatic int cfg_h(input int i);
        case (i)
            2:       return 5;
            3:       return 1;
            default: return 25;
        endcase
    endfunction

    function automatic int cfg_l(input int i);
        case (i)
            1:       return 3;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
        logic [2:0] s;
    } rec_t;

    logic       clock_50;
    logic       reset;
    logic       start        [NI];
    logic [4:0] map_x        [NI];
    logic [4:0] map_y        [NI];
    logic       readwrite    [NI];
    logic [2:0] map_data     [NI];
    logic       out_valid    [NI];
    logic       out_ready    [NI];
    logic [4:0] out_x        [NI];
    logic [4:0] out_y        [NI];
    logic [2:0] out_sprite   [NI];
    logic [9:0] pellet_count [NI];
    logic       busy         [NI];
    logic       done         [NI];

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   act    = -1;
    int   pattern = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   rec_seen = 0;
    logic [2:0] rnd_map [32][32];
    rec_t exp_q [$];
    int   exp_pellets;
    int   exp_cycles;
    int   exp_records;

    initial clock_50 = 1'b0;
    always #5 clock_50 = ~clock_50;
    always @(posedge clock_50) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Map contents as the bench sees them: pattern 0 is (x+y)%8, pattern 1 is
    // a single pellet at (20,24), anything else reads the random table.
    function automatic logic [2:0] sprite_at(input int x, input int y);
        case (pattern)
            0:       return 3'((x + y) % 8);
            1:       return (x == 20 && y == 24) ? 3'd1 : 3'd0;
            default: return rnd_map[x][y];
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [2:0]  pipe [3];
        logic        prev_stall;
        logic        prev_busy;
        logic        prev_valid;
        logic [22:0] held;
        logic [9:0]  prev_addr;

        map_scanner #(
            .MAP_W       (cfg_w(g)),
            .MAP_H       (cfg_h(g)),
            .RD_LAT      (cfg_l(g)),
            .PELLET_CODE (3'd1)
        ) u_dut (
            .clock_50     (clock_50),
            .reset        (reset),
            .start        (start[g]),
            .map_x        (map_x[g]),
            .map_y        (map_y[g]),
            .readwrite    (readwrite[g]),
            .map_data     (map_data[g]),
            .out_valid    (out_valid[g]),
            .out_ready    (out_ready[g]),
            .out_x        (out_x[g]),
            .out_y        (out_y[g]),
            .out_sprite   (out_sprite[g]),
            .pellet_count (pellet_count[g]),
            .busy         (busy[g]),
            .done         (done[g])
        );

        // Map controller with a registered read path RD_LAT deep.
        always @(posedge clock_50) begin
            pipe[0] <= sprite_at(int'(map_x[g]), int'(map_y[g]));
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign map_data[g] = pipe[cfg_l(g) - 1];

        always @(negedge clock_50) begin
            if (reset) begin
                prev_stall = 1'b0;
                prev_busy  = 1'b0;
                prev_valid = 1'b0;
            end else if (act == g) begin
                checkOutput("readwrite", 32'(readwrite[g]), 32'd0);
                if (prev_stall) begin
                    checkOutput("stall_valid", 32'(out_valid[g]), 32'd1);
                    checkOutput("stall_hold",
                        32'({out_x[g], out_y[g], out_sprite[g], map_x[g], map_y[g]}), 32'(held));
                end
                if (out_valid[g] && out_ready[g]) begin
                    rec_seen++;
                    if (exp_q.size() == 0) begin
                        checkOutput("extra_record", 32'(rec_seen), 32'(exp_records));
                    end else begin
                        rec_t r;
                        r = exp_q.pop_front();
                        checkOutput("record", 32'({out_x[g], out_y[g], out_sprite[g]}), 32'(r));
                    end
                end
`ifndef MAP_SCANNER_SKIP_EMPTY_EN
                if (prev_busy && !prev_valid && busy[g])
                    checkOutput("addr_hold", 32'({map_x[g], map_y[g]}), 32'(prev_addr));
`endif
                if (done[g]) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_stall = out_valid[g] && !out_ready[g];
                held       = {out_x[g], out_y[g], out_sprite[g], map_x[g], map_y[g]};
                prev_busy  = busy[g];
                prev_valid = out_valid[g];
                prev_addr  = {map_x[g], map_y[g]};
            end
        end
    end

    // Expected record stream, pellet total and ideal sweep length from the map.
    task automatic build_expect(input int g, input int pat);
        int   s;
        rec_t r;
        exp_q.delete();
        pattern     = pat;
        exp_pellets = 0;
        exp_cycles  = 1;
        for (int y = 0; y < cfg_h(g); y++) begin
            for (int x = 0; x < cfg_w(g); x++) begin
                s = int'(sprite_at(x, y));
                if (s == 1) exp_pellets++;
                if (SKIP_EN && s == 0) begin
                    exp_cycles += cfg_l(g) + 1;
                end else begin
                    r.x = 5'(x);
                    r.y = 5'(y);
                    r.s = 3'(s);
                    exp_q.push_back(r);
                    exp_cycles += cfg_l(g) + 2;
                end
            end
        end
        if (exp_pellets > 1023) exp_pellets = 1023;
        exp_records = exp_q.size();
    endtask

    task automatic applyStimulus(input int g, input int pat, input int ready_pct, input bit poke_start);
        int n;
        int start_cyc;
        build_expect(g, pat);
        act      = g;
        done_cnt = 0;
        rec_seen = 0;
        @(posedge clock_50); #1;
        start[g]     = 1'b1;
        out_ready[g] = ($urandom_range(99) < ready_pct);
        start_cyc    = cyc;
        n = 0;
        do begin
            @(posedge clock_50); #1;
            n++;
            out_ready[g] = ($urandom_range(99) < ready_pct);
            start[g]     = poke_start && (n % 37 == 5);
        end while (done_cnt == 0 && n < SWEEP_LIM);
        start[g]     = 1'b0;
        out_ready[g] = 1'b1;
        checkOutput("sweep_timeout", 32'(n < SWEEP_LIM), 32'd1);
        if (ready_pct >= 100)
            checkOutput("sweep_cycles", 32'(done_cyc - start_cyc), 32'(exp_cycles));
        repeat (4) @(posedge clock_50);
        #1;
        checkOutput("record_count", 32'(rec_seen), 32'(exp_records));
        checkOutput("pellet_count", 32'(pellet_count[g]), 32'(exp_pellets));
        checkOutput("done_pulses", 32'(done_cnt), 32'd1);
        checkOutput("busy_after", 32'(busy[g]), 32'd0);
        checkOutput("done_after", 32'(done[g]), 32'd0);
        act = -1;
    endtask

    // Run into the (10,3) record, hold it, and reset while it is presented.
    task automatic reset_mid_sweep();
        int n;
        int pellets_so_far;
        build_expect(0, 0);
        act      = 0;
        done_cnt = 0;
        rec_seen = 0;
        @(posedge clock_50); #1;
        start[0]     = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clock_50); #1;
        start[0] = 1'b0;
        n = 0;
        while (!(out_valid[0] && out_x[0] == 5'd10 && out_y[0] == 5'd3) && n < SWEEP_LIM) begin
            @(posedge clock_50); #1;
            n++;
        end
        out_ready[0] = 1'b0;
        checkOutput("reach_10_3", 32'(n < SWEEP_LIM), 32'd1);
        pellets_so_far = 0;
        for (int y = 0; y <= 3; y++)
            for (int x = 0; x < ((y == 3) ? 11 : 21); x++)
                if ((x + y) % 8 == 1) pellets_so_far++;
        checkOutput("pellets_before_reset", 32'(pellet_count[0]), 32'(pellets_so_far));
        reset = 1'b1;
        @(posedge clock_50); #1;
        checkOutput("mid_reset_valid", 32'(out_valid[0]), 32'd0);
        checkOutput("mid_reset_busy", 32'(busy[0]), 32'd0);
        checkOutput("mid_reset_pellets", 32'(pellet_count[0]), 32'd0);
        checkOutput("mid_reset_addr", 32'({map_x[0], map_y[0]}), 32'd0);
        reset = 1'b0;
        out_ready[0] = 1'b1;
        act = -1;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start[i]     = 1'b0;
            out_ready[i] = 1'b0;
        end
        for (int x = 0; x < 32; x++)
            for (int y = 0; y < 32; y++)
                rnd_map[x][y] = 3'($urandom_range(7));
        repeat (3) @(posedge clock_50);
        #1;
        for (int i = 0; i < NI; i++) begin
            checkOutput("reset_state",
                32'({out_valid[i], busy[i], done[i], readwrite[i], map_x[i], map_y[i],
                     out_x[i], out_y[i], out_sprite[i]}), 32'd0);
            checkOutput("reset_pellets", 32'(pellet_count[i]), 32'd0);
        end
        reset = 1'b0;

        applyStimulus(0, 0, 100, 1'b0);
        applyStimulus(0, 2, 50, 1'b1);
        reset_mid_sweep();
        applyStimulus(0, 0, 100, 1'b0);
        applyStimulus(1, 2, 50, 1'b0);
        applyStimulus(1, 0, 100, 1'b0);
        applyStimulus(2, 2, 60, 1'b0);
        applyStimulus(2, 2, 100, 1'b0);
        applyStimulus(3, 2, 60, 1'b0);
        applyStimulus(3, 0, 100, 1'b0);
        applyStimulus(0, 1, 100, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/map_scanner.md
Name: map_scanner

Overview:
- Initiator on the map-controller read port: on a start pulse, sweeps every map cell in raster order (x fastest).
- For each cell: drives map_x/map_y with readwrite=0, waits the read latency, captures the 3-bit sprite code.
- Hands each (x, y, sprite) record downstream (renderer / pellet logic) over a valid/ready handshake.
- Keeps a running count of pellet tiles and pulses done at end of sweep.

Parameters:
- MAP_W, 21, map columns (1..32)
- MAP_H, 25, map rows (1..32)
- RD_LAT, 1, clock cycles from address presented to map data valid (1..3)
- PELLET_CODE, 3'd1, sprite code counted as a pellet

Ports:
- clock_50  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a sweep when idle
- map_x  out  5  column address to map controller
- map_y  out  5  row address to map controller
- readwrite  out  1  map access mode; always 0 (read)
- map_data  in  3  sprite data returned by map controller
- out_valid  out  1  tile record valid
- out_ready  in  1  downstream accepts record
- out_x  out  5  record column
- out_y  out  5  record row
- out_sprite  out  3  record sprite code
- pellet_count  out  10  pellets counted in current/last sweep
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse after last record accepted

Behaviour:
- Reset (sync, active-high, takes priority over everything, including mid-sweep): state=IDLE; map_x=0, map_y=0, readwrite=0, out_valid=0, out_x=0, out_y=0, out_sprite=0, pellet_count=0, busy=0, done=0. Any in-flight record is dropped.
- FSM states:
  - IDLE: start=1 -> clear pellet_count, set x=y=0, go ISSUE; busy=1 from next cycle. start is ignored in every state other than IDLE.
  - ISSUE: map_x/map_y hold the current cell; load wait counter with RD_LAT-1; go WAIT.
  - WAIT: count down; at 0, capture map_data into out_sprite (out_x/out_y = current cell); if sprite==PELLET_CODE increment pellet_count; go EMIT.
  - EMIT: out_valid=1 with stable out_x/out_y/out_sprite until out_valid&&out_ready.
    - On handshake, if last cell (x==MAP_W-1, y==MAP_H-1) go DONE.
    - Otherwise advance the cell: x+1, or x=0 and y+1 when x==MAP_W-1. Go ISSUE.
  - DONE: done=1 for exactly one cycle, busy=0, go IDLE. pellet_count holds until the next start.
- Timing and output rules:
  - Best-case throughput: one record per RD_LAT+2 cycles. With RD_LAT=1: ISSUE at cycle 0, capture at cycle 1, out_valid at cycle 2.
  - map_x/map_y stay stable from ISSUE through capture; they are never changed while a read is pending.
  - readwrite is constant 0; the scanner never writes the map.
- Arithmetic: pellet_count is 10 bits (max 32*32=1024 cells saturates at 1023; 21x25=525 never saturates). Saturate, do not wrap.
- Boundaries:
  - MAP_W=1 or MAP_H=1 must sweep correctly.
  - out_ready held low stalls indefinitely with outputs stable.
  - out_ready high in the same cycle out_valid rises is accepted in that cycle.

Optional Feature:
- Macro: MAP_SCANNER_SKIP_EMPTY_EN.
- Defined: cells whose sprite is 3'b000 are not emitted. WAIT goes directly to the advance logic (or DONE if last cell) without asserting out_valid.
  - pellet_count is unaffected.
  - done still pulses after the last cell, even if that cell was skipped.
- Undefined: every cell is emitted, MAP_W*MAP_H records per sweep.

Decomposition:
- Shared package map_pkg:
  - MAP_W/MAP_H defaults
  - coordinate width (5)
  - sprite width (3)
  - sprite code constants (EMPTY=0, PELLET=1, ...)
  - scanner state enum (IDLE, ISSUE, WAIT, EMIT, DONE)
- One natural sub-module: map_cell_counter, the x/y raster counter with wrap and last-cell flag, reusable by other map walkers.

Test Plan:
- Reset, then start with out_ready=1, MAP_W=21, MAP_H=25, map model returning (x+y)%8, RD_LAT=1 -> 525 records in raster order, each sprite correct, pellet_count = number of cells with (x+y)%8==1, done pulses once, busy low afterward.
- out_ready randomly deasserted 50% during a sweep -> no record lost or duplicated; out_x/out_y/out_sprite stable whenever out_valid=1 and out_ready=0.
- Reset asserted while in EMIT mid-sweep (cell 10,3) -> next cycle out_valid=0, busy=0, pellet_count=0, map_x=map_y=0; a new start sweeps from (0,0).
- start pulsed while busy -> ignored, single sweep of 525 records, one done pulse.
- RD_LAT=3 with map model registered three deep -> captured sprite matches the addressed cell; map_x/map_y unchanged for the 3-cycle wait.
- MAP_SCANNER_SKIP_EMPTY_EN defined, all cells empty except (20,24)=PELLET -> exactly one record (20,24,1), pellet_count=1, done pulses after that handshake.
